// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall bit indices,
// controller state encodings and common constants.
package pipe_ctrl_pkg;

    typedef enum logic {
        CTRL_RUN   = 1'b0,
        CTRL_DRAIN = 1'b1
    } ctrl_state_e;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic [4:0]  NOP_REG_ADDR = 5'd0;

    function automatic logic reg_hit(input logic       rd_en,
                                     input logic [4:0] rs,
                                     input logic [4:0] rd);
        return rd_en && (rs == rd);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Combinational load-use comparator: flags a decode-stage source that
// depends on a load still sitting in EX.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_reg1_read,
    input  logic       id_reg2_read,
    input  logic [4:0] id_reg1_addr,
    input  logic [4:0] id_reg2_addr,
    input  logic       ex_is_load,
    input  logic       ex_wreg,
    input  logic [4:0] ex_wd,
    output logic       load_use_o
);

    logic ex_load_writes;

    always_comb begin
        // x0 is never a real producer, so a load into it creates no hazard
        ex_load_writes = ex_is_load && ex_wreg && (ex_wd != NOP_REG_ADDR);
        load_use_o     = ex_load_writes &&
                         (reg_hit(id_reg1_read, id_reg1_addr, ex_wd) ||
                          reg_hit(id_reg2_read, id_reg2_addr, ex_wd));
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline control: stalls, bubbles, flushes, PC redirect and
// stale-fetch draining. Optional performance counters under PIPE_CTRL_PERF_EN.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_W = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rdy,
    input  logic               id_reg1_read,
    input  logic               id_reg2_read,
    input  logic [4:0]         id_reg1_addr,
    input  logic [4:0]         id_reg2_addr,
    input  logic               ex_is_load,
    input  logic               ex_wreg,
    input  logic [4:0]         ex_wd,
    input  logic               ex_jump,
    input  logic [31:0]        ex_jump_target,
    input  logic               mem_busy,
    input  logic               if_busy,
    output logic [STALL_W-1:0] stall_o,
    output logic               flush_if_id_o,
    output logic               flush_id_ex_o,
    output logic               pc_redirect_o,
    output logic [31:0]        pc_target_o,
    output logic               if_discard_o
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]        stall_cnt_o,
    output logic [31:0]        flush_cnt_o
`endif
);

    ctrl_state_e state_q, state_d;
    logic        load_use;

    function automatic logic [STALL_W-1:0] hold_through(input int top);
        logic [STALL_W-1:0] m;
        m = '0;
        for (int k = 0; k < STALL_W; k++) begin
            if (k <= top) m[k] = 1'b1;
        end
        return m;
    endfunction

    pipe_ctrl_hazard_detect u_hazard (
        .id_reg1_read (id_reg1_read),
        .id_reg2_read (id_reg2_read),
        .id_reg1_addr (id_reg1_addr),
        .id_reg2_addr (id_reg2_addr),
        .ex_is_load   (ex_is_load),
        .ex_wreg      (ex_wreg),
        .ex_wd        (ex_wd),
        .load_use_o   (load_use)
    );

    always_comb begin
        stall_o       = '0;
        flush_if_id_o = 1'b0;
        flush_id_ex_o = 1'b0;
        pc_redirect_o = 1'b0;
        pc_target_o   = ZERO_WORD;
        if_discard_o  = 1'b0;
        state_d       = state_q;

        // Outputs are forced quiet while reset is asserted
        if (rst_n) begin
            pc_target_o = ex_jump_target;
            if (!rdy) begin
                stall_o = hold_through(STALL_WB);
            end else begin
                if_discard_o = (state_q == CTRL_DRAIN) && if_busy;

                if (mem_busy) begin
                    stall_o = hold_through(STALL_MEM);
                end else if (ex_jump) begin
                    pc_redirect_o = 1'b1;
                    flush_if_id_o = 1'b1;
                    flush_id_ex_o = 1'b1;
                end else if (load_use) begin
                    stall_o = hold_through(STALL_ID);
                end else if (if_busy) begin
                    stall_o = hold_through(STALL_IF);
                end

                // A redirect orphans whatever fetch is still in flight
                if (pc_redirect_o) begin
                    state_d = (if_busy || state_q == CTRL_DRAIN) ? CTRL_DRAIN : CTRL_RUN;
                end else if (state_q == CTRL_DRAIN && !if_busy) begin
                    state_d = CTRL_RUN;
                end
            end
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (rdy && (stall_o != '0)) stall_cnt_d = stall_cnt_q + 32'd1;
        if (pc_redirect_o)          flush_cnt_d = flush_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= CTRL_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CTRL_RUN;
        end else begin
            state_q <= state_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: the driver queues the expected control
// outputs for each cycle and a negedge monitor compares them.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        id_reg1_read, id_reg2_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr;
    logic        ex_is_load, ex_wreg;
    logic [4:0]  ex_wd;
    logic        ex_jump;
    logic [31:0] ex_jump_target;
    logic        mem_busy, if_busy;
    logic [5:0]  stall_o;
    logic        flush_if_id_o, flush_id_ex_o, pc_redirect_o, if_discard_o;
    logic [31:0] pc_target_o;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

    typedef struct {
        string       nm;
        logic [5:0]  stall;
        logic        flush;
        logic        redir;
        logic        disc;
        logic [31:0] tgt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    pipe_ctrl #(.STALL_W(6)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .rdy            (rdy),
        .id_reg1_read   (id_reg1_read),
        .id_reg2_read   (id_reg2_read),
        .id_reg1_addr   (id_reg1_addr),
        .id_reg2_addr   (id_reg2_addr),
        .ex_is_load     (ex_is_load),
        .ex_wreg        (ex_wreg),
        .ex_wd          (ex_wd),
        .ex_jump        (ex_jump),
        .ex_jump_target (ex_jump_target),
        .mem_busy       (mem_busy),
        .if_busy        (if_busy),
        .stall_o        (stall_o),
        .flush_if_id_o  (flush_if_id_o),
        .flush_id_ex_o  (flush_id_ex_o),
        .pc_redirect_o  (pc_redirect_o),
        .pc_target_o    (pc_target_o),
        .if_discard_o   (if_discard_o)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "timeout");
    end

    // Monitor: the controller presents a decision every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({stall_o, flush_if_id_o, flush_id_ex_o, pc_redirect_o, if_discard_o, pc_target_o} !==
                    {e.stall, e.flush, e.flush, e.redir, e.disc, e.tgt}) begin
                    errors++;
                    $display("FAIL %s: got stall=%b fif=%b fid=%b redir=%b disc=%b tgt=%h, want stall=%b flush=%b redir=%b disc=%b tgt=%h",
                             e.nm, stall_o, flush_if_id_o, flush_id_ex_o, pc_redirect_o, if_discard_o, pc_target_o,
                             e.stall, e.flush, e.redir, e.disc, e.tgt);
                end
            end
        end
    end

    task automatic clear_in();
        rdy = 1'b1;
        id_reg1_read = 1'b0; id_reg2_read = 1'b0;
        id_reg1_addr = 5'd0; id_reg2_addr = 5'd0;
        ex_is_load = 1'b0; ex_wreg = 1'b0; ex_wd = 5'd0;
        ex_jump = 1'b0; mem_busy = 1'b0; if_busy = 1'b0;
    endtask

    // Inputs are already set; queue the expectation and advance one cycle
    task automatic step(input string nm, input logic [5:0] st, input logic fl,
                        input logic rd, input logic dc);
        exp_t e;
        e.nm = nm; e.stall = st; e.flush = fl; e.redir = rd; e.disc = dc;
        e.tgt = rst_n ? ex_jump_target : 32'h0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        ex_jump_target = 32'h0000_1234;
        @(posedge clk);
        #1;

        // Reset holds every output low even with hazards presented
        ex_jump = 1'b1; if_busy = 1'b1; mem_busy = 1'b0;
        step("reset", 6'b000000, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("reset_stall_cnt", stall_cnt_o, 32'd0);
        check_val("reset_flush_cnt", flush_cnt_o, 32'd0);
`endif
        rst_n = 1'b1;
        clear_in();
        ex_jump_target = 32'hDEAD_BEEF;
        step("idle", 6'b000000, 0, 0, 0);
        if_busy = 1'b1;
        step("if_busy", 6'b000011, 0, 0, 0);

        // lw x5 in EX, add x6,x5,x1 in ID
        clear_in();
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd5;
        id_reg1_read = 1'b1; id_reg1_addr = 5'd5;
        id_reg2_read = 1'b1; id_reg2_addr = 5'd1;
        step("lduse_rs1", 6'b000111, 0, 0, 0);
        ex_is_load = 1'b0;
        step("lduse_clear", 6'b000000, 0, 0, 0);
        ex_is_load = 1'b1; id_reg1_addr = 5'd1; id_reg2_addr = 5'd5;
        step("lduse_rs2", 6'b000111, 0, 0, 0);
        id_reg2_read = 1'b0;
        step("lduse_noread", 6'b000000, 0, 0, 0);
        ex_wd = 5'd0; id_reg1_addr = 5'd0; id_reg2_read = 1'b1; id_reg2_addr = 5'd0;
        step("lw_x0", 6'b000000, 0, 0, 0);
        ex_wd = 5'd5; id_reg1_addr = 5'd5; ex_wreg = 1'b0;
        step("load_nowreg", 6'b000000, 0, 0, 0);

        // Taken jump with a fetch outstanding, then drain the stale fetch
        clear_in();
        ex_jump = 1'b1; ex_jump_target = 32'h0000_1000; if_busy = 1'b1;
        step("jump", 6'b000000, 1, 1, 0);
        ex_jump = 1'b0;
        step("drain1", 6'b000011, 0, 0, 1);
        step("drain2", 6'b000011, 0, 0, 1);
        if_busy = 1'b0;
        step("drain_end", 6'b000000, 0, 0, 0);
        if_busy = 1'b1;
        step("run_after", 6'b000011, 0, 0, 0);

        // Jump and load-use together: jump wins, no fetch pending
        clear_in();
        ex_jump = 1'b1; ex_jump_target = 32'h0000_2000;
        ex_is_load = 1'b1; ex_wreg = 1'b1; ex_wd = 5'd7;
        id_reg1_read = 1'b1; id_reg1_addr = 5'd7;
        step("jump_lduse", 6'b000000, 1, 1, 0);
        clear_in();
        if_busy = 1'b1;
        step("no_drain", 6'b000011, 0, 0, 0);

        // Memory busy masks a pending jump for three cycles
        clear_in();
        mem_busy = 1'b1; ex_jump = 1'b1; ex_jump_target = 32'h0000_3000;
        step("membusy1", 6'b011111, 0, 0, 0);
        step("membusy2", 6'b011111, 0, 0, 0);
        step("membusy3", 6'b011111, 0, 0, 0);
        mem_busy = 1'b0;
        step("mem_release", 6'b000000, 1, 1, 0);

        // rdy low mid-DRAIN freezes the state even though if_busy falls
        clear_in();
        ex_jump = 1'b1; ex_jump_target = 32'h0000_4000; if_busy = 1'b1;
        step("jump2", 6'b000000, 1, 1, 0);
        ex_jump = 1'b0; rdy = 1'b0; if_busy = 1'b0;
        step("frozen1", 6'b111111, 0, 0, 0);
        ex_jump = 1'b1;
        step("frozen2", 6'b111111, 0, 0, 0);
        ex_jump = 1'b0; rdy = 1'b1; if_busy = 1'b1;
        step("drain_kept", 6'b000011, 0, 0, 1);

        // Reset pulse mid-DRAIN
        rst_n = 1'b0; ex_jump = 1'b1;
        step("rst_mid", 6'b000000, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("rst_mid_stall_cnt", stall_cnt_o, 32'd0);
        check_val("rst_mid_flush_cnt", flush_cnt_o, 32'd0);
`endif
        rst_n = 1'b1; ex_jump = 1'b0;
        step("post_rst_run", 6'b000011, 0, 0, 0);

        // Four stall cycles in total since reset, then two redirects
        step("stall_b", 6'b000011, 0, 0, 0);
        step("stall_c", 6'b000011, 0, 0, 0);
        step("stall_d", 6'b000011, 0, 0, 0);
        if_busy = 1'b0; ex_jump = 1'b1; ex_jump_target = 32'h0000_5000;
        step("redir_a", 6'b000000, 1, 1, 0);
        ex_jump_target = 32'h0000_6000;
        step("redir_b", 6'b000000, 1, 1, 0);
        ex_jump = 1'b0;
        step("idle_end", 6'b000000, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
        check_val("stall_cnt", stall_cnt_o, 32'd4);
        check_val("flush_cnt", flush_cnt_o, 32'd2);
`endif

        repeat (3) @(negedge clk);
        check_val("sb_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
